arbitrated_multiplexer: RTL and testbench



---
 rtl/interconnect_pkg.sv | 14 +
 rtl/Multiplexer.sv | 13 +
 rtl/round_robin_arbiter.sv | 30 +++
 rtl/arbitrated_multiplexer.sv | 133 +++++++++++++
 tb/tb_arbitrated_multiplexer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/interconnect_pkg.sv
// Shared types for interconnect merge points: channel index and lock-FSM states.
package interconnect_pkg;

    localparam int unsigned CHANNEL_IDX_W = 2;

    // Channel index for the default 4-channel fabric configuration.
    typedef logic [CHANNEL_IDX_W-1:0] channel_idx_t;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/Multiplexer.sv
// Plain select-driven N-to-1 multiplexer; N = 2**NUM_OF_CONTROL_SIGNALS.
module Multiplexer #(
    parameter int unsigned NUM_OF_CONTROL_SIGNALS = 1,
    parameter int unsigned WIDTH                  = 1
) (
    input  logic [NUM_OF_CONTROL_SIGNALS-1:0] sel,
    input  logic [WIDTH-1:0]                  in_data [(2**NUM_OF_CONTROL_SIGNALS)-1:0],
    output logic [WIDTH-1:0]                  out_data
);

    assign out_data = in_data[sel];

endmodule

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter: first masked request at or above priority_ptr, wrapping.
module round_robin_arbiter #(
    parameter int unsigned IDX_W = 1
) (
    input  logic [(2**IDX_W)-1:0] req,
    input  logic [IDX_W-1:0]      priority_ptr,
    input  logic [(2**IDX_W)-1:0] mask,
    output logic [IDX_W-1:0]      grant,
    output logic                  any_valid
);

    localparam int unsigned N = 2**IDX_W;

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        // Index arithmetic wraps naturally because N is a power of two.
        for (int unsigned i = 0; i < N; i++) begin
            idx = priority_ptr + IDX_W'(i);
            if (!any_valid && req[idx] && mask[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitrated_multiplexer.sv
// Registered round-robin N-to-1 multiplexer with valid/ready on every port and optional packet lock.
module arbitrated_multiplexer
    import interconnect_pkg::*;
#(
    parameter int unsigned NUM_OF_CONTROL_SIGNALS = 1,
    parameter int unsigned WIDTH                  = 1,
    parameter bit          PACKET_LOCK            = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [(2**NUM_OF_CONTROL_SIGNALS)-1:0] in_valid,
    input  logic [(2**NUM_OF_CONTROL_SIGNALS)-1:0] in_last,
    input  logic [WIDTH-1:0]                      in_data [(2**NUM_OF_CONTROL_SIGNALS)-1:0],
    output logic [(2**NUM_OF_CONTROL_SIGNALS)-1:0] in_ready,
    output logic                                  out_valid,
    output logic                                  out_last,
    output logic [WIDTH-1:0]                      out_data,
    output logic [NUM_OF_CONTROL_SIGNALS-1:0]     out_channel,
    input  logic                                  out_ready
);

    localparam int unsigned CW = NUM_OF_CONTROL_SIGNALS;
    localparam int unsigned N  = 2**NUM_OF_CONTROL_SIGNALS;

    arb_state_e     state_q, state_d;
    logic [CW-1:0]  locked_ch_q, locked_ch_d;
    logic [CW-1:0]  ptr_q, ptr_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]  out_channel_q, out_channel_d;

    logic           load_c;
    logic           accept_c;
    logic           any_valid_c;
    logic [CW-1:0]  grant_c;
    logic [N-1:0]   mask_c;
    logic [WIDTH-1:0] mux_data_c;

    assign load_c = !out_valid_q || out_ready;
    // While locked only the owning channel is eligible, even if it is idle.
    assign mask_c = (state_q == ARB_LOCKED) ? (N'(1) << locked_ch_q) : '1;

    round_robin_arbiter #(
        .IDX_W (CW)
    ) u_arbiter (
        .req          (in_valid),
        .priority_ptr (ptr_q),
        .mask         (mask_c),
        .grant        (grant_c),
        .any_valid    (any_valid_c)
    );

    Multiplexer #(
        .NUM_OF_CONTROL_SIGNALS (CW),
        .WIDTH                  (WIDTH)
    ) u_mux (
        .sel      (grant_c),
        .in_data  (in_data),
        .out_data (mux_data_c)
    );

    assign accept_c = reset_n && load_c && any_valid_c;
    assign in_ready = accept_c ? (N'(1) << grant_c) : '0;

    // Next-state: output register, pointer and lock FSM.
    always_comb begin
        state_d       = state_q;
        locked_ch_d   = locked_ch_q;
        ptr_d         = ptr_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;

        if (accept_c) begin
            out_valid_d   = 1'b1;
            out_last_d    = in_last[grant_c];
            out_data_d    = mux_data_c;
            out_channel_d = grant_c;
            if (PACKET_LOCK) begin
                // Pointer moves only when a packet closes, never mid-packet.
                case (state_q)
                    ARB_OPEN: begin
                        if (!in_last[grant_c]) begin
                            state_d     = ARB_LOCKED;
                            locked_ch_d = grant_c;
                        end else begin
                            ptr_d = grant_c + CW'(1);
                        end
                    end
                    ARB_LOCKED: begin
                        if (in_last[grant_c]) begin
                            state_d = ARB_OPEN;
                            ptr_d   = grant_c + CW'(1);
                        end
                    end
                    default: state_d = ARB_OPEN;
                endcase
            end else begin
                ptr_d = grant_c + CW'(1);
            end
        end else if (load_c) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_OPEN;
            locked_ch_q   <= '0;
            ptr_q         <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
        end else begin
            state_q       <= state_d;
            locked_ch_q   <= locked_ch_d;
            ptr_q         <= ptr_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;

endmodule

// File: tb/tb_arbitrated_multiplexer.sv
// Bench for arbitrated_multiplexer: directed scenarios plus randomized traffic against a cycle model.
module tb_arbitrated_multiplexer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic [7:0] in_data [3:0];
    logic       out_ready;

    logic [3:0] r0, r1;
    logic       ov0, ov1, ol0, ol1;
    logic [7:0] od0, od1;
    logic [1:0] oc0, oc1;

    logic       sel_nolock = 1'b0;
    logic [3:0] obs_ready;
    logic       obs_ov, obs_ol;
    logic [7:0] obs_od;
    logic [1:0] obs_oc;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit       m_ov, m_ol, m_locked, m_lock_en;
    bit [7:0] m_od;
    int       m_oc, m_ptr, m_lch;

    always #5 clk = ~clk;

    arbitrated_multiplexer #(
        .NUM_OF_CONTROL_SIGNALS (2), .WIDTH (8), .PACKET_LOCK (1'b1)
    ) dut_lock (
        .clk (clk), .reset_n (reset_n), .in_valid (in_valid), .in_last (in_last),
        .in_data (in_data), .in_ready (r0), .out_valid (ov0), .out_last (ol0),
        .out_data (od0), .out_channel (oc0), .out_ready (out_ready)
    );

    arbitrated_multiplexer #(
        .NUM_OF_CONTROL_SIGNALS (2), .WIDTH (8), .PACKET_LOCK (1'b0)
    ) dut_nolock (
        .clk (clk), .reset_n (reset_n), .in_valid (in_valid), .in_last (in_last),
        .in_data (in_data), .in_ready (r1), .out_valid (ov1), .out_last (ol1),
        .out_data (od1), .out_channel (oc1), .out_ready (out_ready)
    );

    assign obs_ready = sel_nolock ? r1  : r0;
    assign obs_ov    = sel_nolock ? ov1 : ov0;
    assign obs_ol    = sel_nolock ? ol1 : ol0;
    assign obs_od    = sel_nolock ? od1 : od0;
    assign obs_oc    = sel_nolock ? oc1 : oc0;

    function automatic void model_reset();
        m_ov = 0; m_ol = 0; m_od = '0; m_oc = 0; m_ptr = 0; m_locked = 0; m_lch = 0;
    endfunction

    // Which channel the spec's rules accept this cycle, as a one-hot vector.
    function automatic logic [3:0] model_ready();
        int c;
        if (!reset_n) return 4'b0000;
        if (m_ov && !out_ready) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (in_valid[c] && (!m_locked || c == m_lch)) return 4'b0001 << c;
        end
        return 4'b0000;
    endfunction

    function automatic void model_update();
        logic [3:0] r;
        int c;
        r = model_ready();
        if (r != 4'b0000) begin
            c = 0;
            for (int k = 0; k < 4; k++) if (r[k]) c = k;
            m_ov = 1; m_od = in_data[c]; m_ol = in_last[c]; m_oc = c;
            if (m_lock_en && !m_locked && !in_last[c]) begin
                m_locked = 1; m_lch = c;
            end else if (m_locked && !in_last[c]) begin
                m_locked = 1;
            end else begin
                m_locked = 0; m_ptr = (c + 1) % 4;
            end
        end else if (!m_ov || out_ready) begin
            m_ov = 0;
        end
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; in_valid = '0; in_last = '0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) in_data[c] = '0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) in_data[c] = 8'h80 + 8'(c);
        repeat (2) @(negedge clk);
        n_cmp++; if (obs_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0000", obs_ready); end
        n_cmp++; if (obs_ov !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", obs_ov); end
        n_cmp++; if (obs_od !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", obs_od); end
        n_cmp++; if (obs_oc !== 2'd0 || obs_ol !== 1'b0) begin n_bad++; $display("FAIL reset_chan_last: got %0d/%b want 0/0", obs_oc, obs_ol); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (obs_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant: got %b want 0001", obs_ready); end
        @(negedge clk);
        n_cmp++; if (obs_ov !== 1'b1 || obs_oc !== 2'd0 || obs_od !== 8'h80) begin
            n_bad++; $display("FAIL reset_first_beat: got v%b ch%0d %h want v1 ch0 80", obs_ov, obs_oc, obs_od);
        end
    endtask

    task automatic test_fairness();
        int e;
        do_reset();
        in_valid = 4'b1111; in_last = 4'b1111;
        for (int c = 0; c < 4; c++) in_data[c] = 8'h10 + 8'(c);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_cmp++; if (obs_ready !== (4'b0001 << (i % 4))) begin n_bad++; $display("FAIL fair_ready[%0d]: got %b want %b", i, obs_ready, 4'b0001 << (i % 4)); end
            if (i > 0) begin
                e = (i - 1) % 4;
                n_cmp++; if (obs_ov !== 1'b1 || obs_oc !== 2'(e) || obs_od !== 8'h10 + 8'(e)) begin
                    n_bad++; $display("FAIL fair_out[%0d]: got v%b ch%0d %h want v1 ch%0d %h", i, obs_ov, obs_oc, obs_od, e, 8'h10 + 8'(e));
                end
            end
            @(posedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 4'b0001; in_last = 4'b0001; in_data[0] = 8'hA5;
        @(negedge clk);
        n_cmp++; if (obs_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_first_ready: got %b want 0001", obs_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0; in_data[0] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (obs_ov !== 1'b1 || obs_od !== 8'hA5 || obs_ready !== 4'b0000) begin
                n_bad++; $display("FAIL bp_stall[%0d]: got v%b %h rdy%b want v1 a5 rdy0000", i, obs_ov, obs_od, obs_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (obs_ready !== 4'b0001 || obs_od !== 8'hA5) begin n_bad++; $display("FAIL bp_release: got rdy%b %h want 0001 a5", obs_ready, obs_od); end
        @(negedge clk);
        n_cmp++; if (obs_ov !== 1'b1 || obs_od !== 8'h5A) begin n_bad++; $display("FAIL bp_next: got v%b %h want v1 5a", obs_ov, obs_od); end
    endtask

    task automatic test_lock();
        logic       v2 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] d2 [6] = '{8'h20, 8'h21, 8'h21, 8'h22, 8'h22, 8'h22};
        logic       l2 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       v0 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] er [6] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0001, 4'b0000};
        logic       eov[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0] eoc[6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        logic [7:0] eod[6] = '{8'h11, 8'h20, 8'h21, 8'h21, 8'h22, 8'h0F};
        logic       eol[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        // One beat on channel 1 moves the pointer to channel 2.
        in_valid = 4'b0010; in_last = 4'b0010; in_data[1] = 8'h11;
        @(posedge clk); #1;
        in_data[0] = 8'h0F; in_last[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = {1'b0, v2[k], 1'b0, v0[k]};
            in_data[2] = d2[k]; in_last[2] = l2[k];
            @(negedge clk);
            n_cmp++; if (obs_ready !== er[k]) begin n_bad++; $display("FAIL lock_ready[%0d]: got %b want %b", k, obs_ready, er[k]); end
            n_cmp++; if (obs_ov !== eov[k] || (eov[k] && (obs_oc !== eoc[k] || obs_od !== eod[k] || obs_ol !== eol[k]))) begin
                n_bad++; $display("FAIL lock_out[%0d]: got v%b ch%0d %h l%b want v%b ch%0d %h l%b",
                                  k, obs_ov, obs_oc, obs_od, obs_ol, eov[k], eoc[k], eod[k], eol[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_midpacket_reset();
        do_reset();
        in_valid = 4'b0010; in_last = 4'b0000; in_data[1] = 8'h31;
        @(negedge clk);
        n_cmp++; if (obs_ready !== 4'b0010) begin n_bad++; $display("FAIL mrst_beat1: got %b want 0010", obs_ready); end
        @(posedge clk); #1;
        in_data[1] = 8'h32;
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if (obs_ov !== 1'b0 || obs_ready !== 4'b0000) begin n_bad++; $display("FAIL mrst_async: got v%b rdy%b want v0 0000", obs_ov, obs_ready); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        in_valid = 4'b1000; in_last = 4'b1000; in_data[3] = 8'h3C;
        @(negedge clk);
        n_cmp++; if (obs_ready !== 4'b1000) begin n_bad++; $display("FAIL mrst_ch3_ready: got %b want 1000", obs_ready); end
        @(negedge clk);
        n_cmp++; if (obs_ov !== 1'b1 || obs_oc !== 2'd3 || obs_od !== 8'h3C) begin
            n_bad++; $display("FAIL mrst_ch3_out: got v%b ch%0d %h want v1 ch3 3c", obs_ov, obs_oc, obs_od);
        end
    endtask

    task automatic test_nolock();
        logic [3:0] er [5] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000};
        logic [1:0] eoc[5] = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3};
        logic [7:0] eod[5] = '{8'h00, 8'h41, 8'h61, 8'h42, 8'h62};
        int b1 = 0;
        int b3 = 0;
        sel_nolock = 1'b1;
        do_reset();
        in_valid = 4'b1010; in_last = 4'b0000; in_data[1] = 8'h41; in_data[3] = 8'h61;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (obs_ready !== er[k]) begin n_bad++; $display("FAIL nolock_ready[%0d]: got %b want %b", k, obs_ready, er[k]); end
            if (k > 0) begin
                n_cmp++; if (obs_ov !== 1'b1 || obs_oc !== eoc[k] || obs_od !== eod[k]) begin
                    n_bad++; $display("FAIL nolock_out[%0d]: got v%b ch%0d %h want v1 ch%0d %h", k, obs_ov, obs_oc, obs_od, eoc[k], eod[k]);
                end
            end
            @(posedge clk); #1;
            if (er[k][1]) begin
                b1++;
                if (b1 == 1) begin in_data[1] = 8'h42; in_last[1] = 1'b1; end else in_valid[1] = 1'b0;
            end
            if (er[k][3]) begin
                b3++;
                if (b3 == 1) begin in_data[3] = 8'h62; in_last[3] = 1'b1; end else in_valid[3] = 1'b0;
            end
        end
        sel_nolock = 1'b0;
    endtask

    task automatic test_random(input bit nolock, input int cycles);
        bit       pv [4];
        bit       pl [4];
        bit [7:0] pd [4];
        logic [3:0] er;
        sel_nolock = nolock;
        m_lock_en  = !nolock;
        do_reset();
        for (int c = 0; c < 4; c++) begin pv[c] = 0; pl[c] = 0; pd[c] = '0; end
        for (int cyc = 0; cyc < cycles; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                in_valid[c] = pv[c]; in_last[c] = pl[c]; in_data[c] = pd[c];
            end
            @(negedge clk);
            er = model_ready();
            n_cmp++; if (obs_ready !== er) begin n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, obs_ready, er); end
            n_cmp++; if (obs_ov !== m_ov || obs_od !== m_od || obs_ol !== m_ol || obs_oc !== 2'(m_oc)) begin
                n_bad++; $display("FAIL rand_out[%0d]: got v%b %h l%b ch%0d want v%b %h l%b ch%0d",
                                  cyc, obs_ov, obs_od, obs_ol, obs_oc, m_ov, m_od, m_ol, m_oc);
            end
            model_update();
            @(posedge clk); #1;
            for (int c = 0; c < 4; c++) begin
                if (er[c]) pv[c] = 0;
                if (!pv[c] && $urandom_range(0, 1) == 1) begin
                    pv[c] = 1; pd[c] = 8'($urandom); pl[c] = ($urandom_range(0, 2) == 0);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        sel_nolock = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = '0; in_last = '0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) in_data[c] = '0;
        m_lock_en = 1'b1;
        model_reset();
        test_reset();
        test_fairness();
        test_backpressure();
        test_lock();
        test_midpacket_reset();
        test_random(1'b0, 400);
        test_nolock();
        test_random(1'b1, 300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
